// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin on conflict, one transaction in flight,
// stores take ISSUE only, loads take ISSUE then RESP to return read data.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic                lat_id_q, lat_id_d;
  logic                lat_we_q, lat_we_d;
  logic                lat_byte_q, lat_byte_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic                last_gnt_q, last_gnt_d;
  logic                sel;
  logic                issue, resp;

  always_comb begin
    state_d     = state_q;
    lat_id_d    = lat_id_q;
    lat_we_d    = lat_we_q;
    lat_byte_d  = lat_byte_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    last_gnt_d  = last_gnt_q;
    // On conflict pick the requester that did not win last; otherwise whoever asks.
    sel         = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          lat_id_d    = sel;
          lat_we_d    = sel ? m1_we    : m0_we;
          lat_byte_d  = sel ? m1_byte  : m0_byte;
          lat_addr_d  = sel ? m1_addr  : m0_addr;
          lat_wdata_d = sel ? m1_wdata : m0_wdata;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        last_gnt_d = lat_id_q;
        state_d    = lat_we_q ? StIdle : StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      lat_id_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_byte_q  <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      last_gnt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_id_q    <= lat_id_d;
      lat_we_q    <= lat_we_d;
      lat_byte_q  <= lat_byte_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  // Outputs are forced low while reset is held so an aborted access never pulses.
  assign issue     = rst && (state_q == StIssue);
  assign resp      = rst && (state_q == StResp);

  assign mem_en    = issue;
  assign mem_we    = issue && lat_we_q;
  assign mem_byte  = issue && lat_byte_q;
  assign mem_addr  = rst ? lat_addr_q  : '0;
  assign mem_wdata = rst ? lat_wdata_q : '0;

  assign m0_gnt    = issue && !lat_id_q;
  assign m1_gnt    = issue &&  lat_id_q;
  assign m0_rvalid = resp  && !lat_id_q;
  assign m1_rvalid = resp  &&  lat_id_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  assign busy      = rst && (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_byte, m1_req, m1_we, m1_byte;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, mem_byte, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte(m0_byte), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte(m1_byte), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one committed transaction, age counted in cycles since commit.
  int          m_age = 0;   // 0 = nothing in flight, 1 = strobe cycle, 2 = data cycle
  int          m_len = 0;   // 1 for a store, 2 for a load
  logic        m_last = 1'b1;
  logic        t_id = 1'b0, t_we = 1'b0, t_byte = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;

  // Observations taken from the DUT for directed scenario checks.
  logic [31:0] gq[$];
  int          g0_cnt = 0, g1_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, en_cnt = 0;
  int          g0_cyc = 0, rv0_cyc = 0;
  logic [31:0] rv_data = '0, en_addr = '0, en_wdata = '0;
  logic        en_we = 1'b0, en_byte = 1'b0, last_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic on, st, dt;
    on = (rst === 1'b1);
    st = on && (m_age == 1);
    dt = on && (m_age == 2);
    chk("gnt0",   32'(m0_gnt),    32'(st && !t_id));
    chk("gnt1",   32'(m1_gnt),    32'(st &&  t_id));
    chk("rvalid0", 32'(m0_rvalid), 32'(dt && !t_id));
    chk("rvalid1", 32'(m1_rvalid), 32'(dt &&  t_id));
    chk("rdata0", m0_rdata, (dt && !t_id) ? mem_rdata : 32'h0);
    chk("rdata1", m1_rdata, (dt &&  t_id) ? mem_rdata : 32'h0);
    chk("mem_en", 32'(mem_en),    32'(st));
    chk("mem_we", 32'(mem_we),    32'(st && t_we));
    chk("mem_byte", 32'(mem_byte), 32'(st && t_byte));
    chk("mem_addr", mem_addr,     on ? t_addr : 32'h0);
    chk("mem_wdata", mem_wdata,   on ? t_wdata : 32'h0);
    chk("busy",   32'(busy),      32'(on && (m_age != 0)));
    if (m0_gnt === 1'b1) begin gq.push_back(32'd0); g0_cnt++; g0_cyc = cyc; end
    if (m1_gnt === 1'b1) begin gq.push_back(32'd1); g1_cnt++; end
    if (m0_rvalid === 1'b1) begin rv0_cnt++; rv0_cyc = cyc; rv_data = m0_rdata; end
    if (m1_rvalid === 1'b1) begin rv1_cnt++; rv_data = m1_rdata; end
    if (mem_en === 1'b1) begin
      en_cnt++; en_addr = mem_addr; en_wdata = mem_wdata; en_we = mem_we; en_byte = mem_byte;
    end
    last_busy = busy;
  endtask

  task automatic model_update();
    logic pick;
    if (rst !== 1'b1) begin
      m_age = 0; m_last = 1'b1;
      t_id = 1'b0; t_we = 1'b0; t_byte = 1'b0; t_addr = '0; t_wdata = '0;
    end else if (m_age == 0) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) pick = !m_last;
        else                  pick = m1_req;
        t_id    = pick;
        t_we    = pick ? m1_we    : m0_we;
        t_byte  = pick ? m1_byte  : m0_byte;
        t_addr  = pick ? m1_addr  : m0_addr;
        t_wdata = pick ? m1_wdata : m0_wdata;
        m_len   = t_we ? 1 : 2;
        m_age   = 1;
      end
    end else begin
      if (m_age == 1) m_last = t_id;
      m_age = (m_age == m_len) ? 0 : m_age + 1;
    end
  endtask

  task automatic cycle();
    cyc++;
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    int t0, g1b, rv1b, g0b, enb, rv0b;
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_byte = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_byte = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();

    // Single load from requester 0.
    mem_rdata = 32'hDEADBEEF;
    m0_req = 1; m0_we = 0; m0_byte = 0; m0_addr = 32'h10;
    t0 = cyc + 1;
    cycle();
    m0_req = 0;
    repeat (3) cycle();
    chk("ld0_gnt_cycle",   32'(g0_cyc),  32'(t0 + 1));
    chk("ld0_rv_cycle",    32'(rv0_cyc), 32'(t0 + 2));
    chk("ld0_rdata",       rv_data,      32'hDEADBEEF);
    chk("ld0_mem_addr",    en_addr,      32'h10);

    // Single byte store from requester 1.
    g1b = g1_cnt; rv1b = rv1_cnt; enb = en_cnt;
    m1_req = 1; m1_we = 1; m1_byte = 1; m1_addr = 32'h20; m1_wdata = 32'h000000A5;
    cycle();
    m1_req = 0;
    repeat (3) cycle();
    chk("st1_gnt",   32'(g1_cnt - g1b),  32'd1);
    chk("st1_norv",  32'(rv1_cnt - rv1b), 32'd0);
    chk("st1_en",    32'(en_cnt - enb),  32'd1);
    chk("st1_webyte", {30'd0, en_we, en_byte}, 32'd3);
    chk("st1_addr",  en_addr,  32'h20);
    chk("st1_wdata", en_wdata, 32'hA5);

    // Both requesting after reset: strict alternation starting with 0.
    rst = 1'b0; cycle(); rst = 1'b1;
    gq.delete();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1; m1_byte = 0;
    repeat (10) cycle();
    m0_req = 0; m1_req = 0;
    repeat (3) cycle();
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < gq.size()) ? gq[i] : 32'hFFFFFFFF, 32'(i % 2));

    // Reset while a load sits in its data cycle.
    rv0b = rv0_cnt;
    m0_req = 1; m0_we = 0;
    cycle();
    m0_req = 0;
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_resp_norv", 32'(rv0_cnt - rv0b), 32'd0);
    chk("rst_resp_busy", 32'(last_busy), 32'd0);

    // A one-cycle m0 pulse during an m1 strobe is dropped.
    g0b = g0_cnt; g1b = g1_cnt;
    m1_req = 1; m1_we = 1;
    cycle();
    m1_req = 0; m0_req = 1; m0_we = 1;
    cycle();
    m0_req = 0;
    repeat (4) cycle();
    chk("busy_ignore_g0", 32'(g0_cnt - g0b), 32'd0);
    chk("busy_ignore_g1", 32'(g1_cnt - g1b), 32'd1);

    // m1 load committed, request dropped afterwards, still completes.
    g1b = g1_cnt; rv1b = rv1_cnt;
    m1_req = 1; m1_we = 0; mem_rdata = 32'h12345678;
    cycle();
    m1_req = 0;
    repeat (3) cycle();
    chk("commit_g1",  32'(g1_cnt - g1b),  32'd1);
    chk("commit_rv1", 32'(rv1_cnt - rv1b), 32'd1);
    chk("commit_data", rv_data, 32'h12345678);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      m0_req = ($urandom_range(0, 2) != 0);
      m1_req = ($urandom_range(0, 2) != 0);
      m0_we = 1'($urandom_range(0, 1)); m0_byte = 1'($urandom_range(0, 1));
      m1_we = 1'($urandom_range(0, 1)); m1_byte = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m0_wdata = $urandom;
      m1_addr = $urandom; m1_wdata = $urandom;
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of both requesters and the memory port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have ports m0_req / m1_req  input  1  access request from requester 0 (core) / requester 1 (loader).
REQ-006 SHALL have ports mN_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports mN_byte  input  1  byte access (sb/lb), 0 = word.
REQ-008 SHALL have ports mN_addr  input  ADDR_W  byte address.
REQ-009 SHALL have ports mN_wdata  input  DATA_W  store data.
REQ-010 SHALL have ports mN_gnt  output  1  one-cycle grant pulse.
REQ-011 SHALL have ports mN_rvalid  output  1  one-cycle load-data-valid pulse.
REQ-012 SHALL have ports mN_rdata  output  DATA_W  load data, meaningful only while mN_rvalid = 1.
REQ-013 SHALL have ports mem_en, mem_we, mem_byte  output  1  memory strobe, write enable, byte mode.
REQ-014 SHALL have ports mem_addr  output  ADDR_W and mem_wdata  output  DATA_W  memory address/store data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after a read strobe.
REQ-016 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-018 IDLE, no req: SHALL stay IDLE, all strobes 0.
REQ-019 IDLE, exactly one req: SHALL latch that requester's we/byte/addr/wdata and requester ID, go to ISSUE.
REQ-020 IDLE, both req: SHALL select the requester not recorded in last_gnt (round-robin), latch it, go to ISSUE.
REQ-021 ISSUE: SHALL drive mem_en = 1 and mem_we/mem_byte/mem_addr/mem_wdata from latched values for exactly one cycle, pulse gnt of the latched requester, and update last_gnt to that ID.
REQ-022 ISSUE with latched we = 1: SHALL return to IDLE next cycle (store = 2 cycles req-to-IDLE).
REQ-023 ISSUE with latched we = 0: SHALL go to RESP; in RESP pulse rvalid of the latched requester with rdata = mem_rdata, then return to IDLE (load = 3 cycles).
REQ-024 mN_rdata of a requester SHALL be 0 whenever its rvalid = 0; the other requester's rvalid SHALL never assert.
REQ-025 Request sampled in IDLE SHALL be committed; deasserting req afterwards SHALL NOT cancel it.
REQ-026 Requester still asserting req after gnt SHALL be treated as a new request on the next IDLE cycle.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no queuing beyond the latched transaction.
REQ-028 Under continuous requests from both, SHALL alternate grants 0,1,0,1... (no starvation).
REQ-029 mem_en, mem_we, mem_byte SHALL be 0 outside ISSUE; mem_addr/mem_wdata SHALL hold latched values.
REQ-030 Addresses SHALL pass unmodified; no alignment checks; byte sign-extension remains the memory's job.

Reset
REQ-031 rst = 0 at a rising edge SHALL force IDLE from any state, aborting an in-flight access with no gnt/rvalid.
REQ-032 During and after reset all outputs SHALL be 0, latched fields 0, last_gnt = 1 (requester 0 wins the first conflict).

Verification
REQ-033 Single load m0, addr 0x10, mem_rdata 0xDEADBEEF -> gnt0 in cycle 2, mem_en with addr 0x10 in cycle 2, rvalid0 with rdata 0xDEADBEEF in cycle 3.
REQ-034 Single store m1, addr 0x20, wdata 0x000000A5, byte = 1 -> mem_en/mem_we/mem_byte high one cycle, addr 0x20, wdata 0xA5, gnt1 pulse, no rvalid.
REQ-035 Both req held after reset, 4 transactions -> grant order 0,1,0,1.
REQ-036 Reset asserted in RESP state -> next cycle IDLE, rvalid never pulses, busy = 0.
REQ-037 m0_req pulsed one cycle while m1 transaction in ISSUE -> request ignored, no gnt0.
REQ-038 m1 load committed, m1_req dropped in ISSUE -> transaction completes with gnt1 and rvalid1.
